// File: rtl/silencer_fixed_step_pkg.sv
// Shared types and sizing for the fixed-step silencer.
// Imported by the top and by the step calculator.
package silencer_fixed_step_pkg;

  localparam int NumTransducers = 249;

  typedef struct packed {
    logic [7:0] step_intensity;
    logic [7:0] step_phase;
  } silencer_settings_t;

  typedef struct packed {
    logic [7:0] intensity;
    logic [7:0] phase;
  } drive_t;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/silencer_step_calc.sv
// Single-channel slew limiter: move cur toward tgt by at most step.
// Phase mode takes the short way round the 256-count circle.
module silencer_step_calc
  import silencer_fixed_step_pkg::*;
(
  input  logic [7:0] i_cur,
  input  logic [7:0] i_tgt,
  input  logic [7:0] i_step,
  input  logic       i_is_phase,
  output logic [7:0] o_new
);

  logic [7:0] w_diff;
  logic [7:0] w_mag_lin;
  logic [7:0] w_mag_ph;
  logic [7:0] w_mag;
  logic       w_up_lin;
  logic       w_neg_ph;
  logic       w_up;

  always_comb begin
    w_diff    = i_tgt - i_cur;
    w_up_lin  = i_tgt > i_cur;
    w_mag_lin = w_up_lin ? w_diff : (i_cur - i_tgt);
    // A half-turn difference (0x80) counts as positive.
    w_neg_ph  = w_diff[7] && (w_diff != 8'h80);
    w_mag_ph  = w_neg_ph ? (~w_diff + 8'd1) : w_diff;
    w_mag     = i_is_phase ? w_mag_ph : w_mag_lin;
    w_up      = i_is_phase ? !w_neg_ph : w_up_lin;
    o_new     = i_tgt;
    if (w_mag > i_step) begin
      o_new = w_up ? (i_cur + i_step) : (i_cur - i_step);
    end
  end

endmodule

// File: rtl/silencer_fixed_step.sv
// Per-transducer slew limiter between modulation and PWM encoding.
// Three-stage pipeline over a DEPTH-entry intensity/phase state memory.
module silencer_fixed_step
  import silencer_fixed_step_pkg::*;
#(
  parameter int DEPTH = NumTransducers
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] STEP_INTENSITY,
  input  logic [7:0] STEP_PHASE,
  input  logic       DIN_VALID,
  input  logic [7:0] INTENSITY_IN,
  input  logic [7:0] PHASE_IN,
  output logic [7:0] INTENSITY_OUT,
  output logic [7:0] PHASE_OUT,
  output logic       DOUT_VALID,
  output logic       READY
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [AW-1:0]      r_init_addr;
  logic [AW-1:0]      r_idx;
  silencer_settings_t r_step_frame;
  silencer_settings_t w_step_in;
  silencer_settings_t w_step;
  logic               w_accept;
  logic               w_first;

  logic               r1_valid;
  logic [AW-1:0]      r1_idx;
  drive_t             r1_tgt;
  silencer_settings_t r1_step;
  drive_t             r_rd;

  drive_t             w_new;
  logic               r2_valid;
  logic [AW-1:0]      r2_idx;
  drive_t             r2_new;

  logic               r_dout_valid;
  drive_t             r_out;

  drive_t             r_mem [DEPTH];
  logic               w_we;
  logic [AW-1:0]      w_waddr;
  drive_t             w_wdata;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= StInit;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r2_idx;
    w_wdata     = r2_new;
    unique case (r_state)
      StInit: begin
        w_we    = 1'b1;
        w_waddr = r_init_addr;
        w_wdata = '0;
        if (r_init_addr == LastIdx) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        w_we = r2_valid;
      end
      default: w_state_nxt = StInit;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_init_addr <= '0;
    end else if (r_state == StInit) begin
      r_init_addr <= (r_init_addr == LastIdx) ? '0 : r_init_addr + 1'b1;
    end
  end

  assign w_accept  = (r_state == StRun) && DIN_VALID;
  assign w_first   = (r_idx == '0);
  assign w_step_in = '{step_intensity: STEP_INTENSITY,
                       step_phase:     STEP_PHASE};
  // Index 0 uses the live inputs; the rest of the frame reuses them.
  assign w_step    = w_first ? w_step_in : r_step_frame;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx        <= '0;
      r_step_frame <= '0;
    end else if (w_accept) begin
      r_idx <= (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
      if (w_first) r_step_frame <= w_step_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r1_valid <= 1'b0;
      r1_idx   <= '0;
      r1_tgt   <= '0;
      r1_step  <= '0;
    end else begin
      r1_valid <= w_accept;
      if (w_accept) begin
        r1_idx  <= r_idx;
        r1_tgt  <= '{intensity: INTENSITY_IN, phase: PHASE_IN};
        r1_step <= w_step;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) r_rd <= r_mem[r_idx];
  end

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  silencer_step_calc u_calc_int (
    .i_cur      (r_rd.intensity),
    .i_tgt      (r1_tgt.intensity),
    .i_step     (r1_step.step_intensity),
    .i_is_phase (1'b0),
    .o_new      (w_new.intensity)
  );

  silencer_step_calc u_calc_ph (
    .i_cur      (r_rd.phase),
    .i_tgt      (r1_tgt.phase),
    .i_step     (r1_step.step_phase),
    .i_is_phase (1'b1),
    .o_new      (w_new.phase)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r2_valid <= 1'b0;
      r2_idx   <= '0;
      r2_new   <= '0;
    end else begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_idx <= r1_idx;
        r2_new <= w_new;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout_valid <= 1'b0;
      r_out        <= '0;
    end else begin
      r_dout_valid <= r2_valid;
      if (r2_valid) r_out <= r2_new;
    end
  end

  assign INTENSITY_OUT = r_out.intensity;
  assign PHASE_OUT     = r_out.phase;
  assign DOUT_VALID    = r_dout_valid;
  assign READY         = (r_state == StRun);

endmodule

// File: tb/tb_silencer_fixed_step.sv
// Scoreboard bench for silencer_fixed_step against an arithmetic model.
// Random targets and gaps, plus directed ramp/wrap/freeze/reset frames.
module tb_silencer_fixed_step;

  localparam int DEPTH = 249;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] step_i = '0;
  logic [7:0] step_p = '0;
  logic       din_valid = 1'b0;
  logic [7:0] int_in = '0;
  logic [7:0] ph_in = '0;
  logic [7:0] int_out;
  logic [7:0] ph_out;
  logic       dout_valid;
  logic       ready;

  silencer_fixed_step #(.DEPTH(DEPTH)) dut (
    .CLK            (clk),
    .RST            (rst),
    .STEP_INTENSITY (step_i),
    .STEP_PHASE     (step_p),
    .DIN_VALID      (din_valid),
    .INTENSITY_IN   (int_in),
    .PHASE_IN       (ph_in),
    .INTENSITY_OUT  (int_out),
    .PHASE_OUT      (ph_out),
    .DOUT_VALID     (dout_valid),
    .READY          (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int ei;
    int ep;
    int exp_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   obs_i[DEPTH];
  int   obs_p[DEPTH];

  int   m_cur_i[DEPTH];
  int   m_cur_p[DEPTH];
  int   m_idx = 0;
  int   m_si = 0;
  int   m_sp = 0;
  logic [7:0] tgt_i[DEPTH];
  logic [7:0] tgt_p[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lim_int(input int c, input int t, input int s);
    int d;
    d = t - c;
    if (d <= s && d >= -s) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  function automatic int lim_ph(input int c, input int t, input int s);
    int d;
    d = ((t - c) % 256 + 256) % 256;
    if (d > 128) d = d - 256;
    if (d <= s && d >= -s) return t;
    return (d > 0) ? (c + s) % 256 : (c - s + 256) % 256;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].exp_cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_dout ch%0d: got none expected at cycle %0d",
               e.ch, e.exp_cyc);
    end
    if (dout_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout: got valid at cycle %0d expected none",
                 cyc);
      end else begin
        e = q.pop_front();
        chk($sformatf("latency_ch%0d", e.ch), cyc, e.exp_cyc);
        chk($sformatf("int_ch%0d", e.ch), int'(int_out), e.ei);
        chk($sformatf("ph_ch%0d", e.ch), int'(ph_out), e.ep);
        obs_i[e.ch] = int'(int_out);
        obs_p[e.ch] = int'(ph_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      int_in = 8'($urandom);
      ph_in  = 8'($urandom);
      tick();
    end
  endtask

  task automatic drive_beat(input logic [7:0] ti, input logic [7:0] tp);
    exp_t e;
    din_valid = 1'b1;
    int_in    = ti;
    ph_in     = tp;
    if (ready && !rst) begin
      if (m_idx == 0) begin
        m_si = int'(step_i);
        m_sp = int'(step_p);
      end
      m_cur_i[m_idx] = lim_int(m_cur_i[m_idx], int'(ti), m_si);
      m_cur_p[m_idx] = lim_ph(m_cur_p[m_idx], int'(tp), m_sp);
      e.ch      = m_idx;
      e.ei      = m_cur_i[m_idx];
      e.ep      = m_cur_p[m_idx];
      e.exp_cyc = cyc + 3;
      q.push_back(e);
      m_idx = (m_idx + 1) % DEPTH;
    end
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_reset(input bit with_beat);
    exp_t keep[$];
    int   early;
    rst = 1'b1;
    if (with_beat) begin
      din_valid = 1'b1;
      int_in    = 8'($urandom);
      ph_in     = 8'($urandom);
    end
    foreach (q[k]) if (q[k].exp_cyc <= cyc) keep.push_back(q[k]);
    q = keep;
    for (int c = 0; c < DEPTH; c++) begin
      m_cur_i[c] = 0;
      m_cur_p[c] = 0;
    end
    m_idx = 0;
    tick();
    din_valid = 1'b0;
    chk("rst_int_out", int'(int_out), 0);
    chk("rst_ph_out", int'(ph_out), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_ready", int'(ready), 0);
    tick();
    rst   = 1'b0;
    early = 0;
    for (int k = 0; k < DEPTH; k++) begin
      din_valid = 1'($urandom);
      int_in    = 8'($urandom);
      ph_in     = 8'($urandom);
      @(negedge clk);
      if (ready !== 1'b0) early++;
      tick();
    end
    din_valid = 1'b0;
    chk("init_ready_low_cycles", early, 0);
    chk("init_ready_high", int'(ready), 1);
  endtask

  task automatic rand_tgts();
    for (int c = 0; c < DEPTH; c++) begin
      tgt_i[c] = 8'($urandom);
      tgt_p[c] = 8'($urandom);
    end
  endtask

  // gmode: 0 none, 1 seven-cycle gaps after beats 0 and 100, 2 random
  task automatic run_frame(input int si, input int sp, input int gmode,
                           input int chg_at, input int csi, input int csp,
                           input int rst_at);
    step_i = 8'(si);
    step_p = 8'(sp);
    for (int c = 0; c < DEPTH; c++) begin
      if (c == rst_at) begin
        do_reset(1'b1);
        return;
      end
      if (c == chg_at) begin
        step_i = 8'(csi);
        step_p = 8'(csp);
      end
      drive_beat(tgt_i[c], tgt_p[c]);
      if (gmode == 1 && (c == 0 || c == 100)) idle(7);
      if (gmode == 2 && $urandom_range(0, 7) == 0) idle($urandom_range(1, 4));
    end
    idle(5);
  endtask

  task automatic set_dir(input int i5, input int p7);
    rand_tgts();
    tgt_i[5] = 8'(i5);
    tgt_p[7] = 8'(p7);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int up_i[4];
    int up_p[4];
    int dn_i[4];
    up_i = '{20, 30, 35, 35};
    up_p = '{253, 0, 3, 4};
    dn_i = '{25, 15, 5, 0};

    do_reset(1'b0);

    set_dir(35, 250);
    run_frame(10, 255, 0, -1, 0, 0, -1);
    chk("ramp_i_f1", obs_i[5], 10);
    chk("wrap_p_f1", obs_p[7], 250);
    for (int f = 0; f < 4; f++) begin
      set_dir(35, 4);
      run_frame(10, 3, 0, -1, 0, 0, -1);
      chk($sformatf("ramp_i_f%0d", f + 2), obs_i[5], up_i[f]);
      chk($sformatf("wrap_p_f%0d", f + 2), obs_p[7], up_p[f]);
    end
    for (int f = 0; f < 4; f++) begin
      set_dir(0, 4);
      run_frame(10, 3, 2, -1, 0, 0, -1);
      chk($sformatf("ramp_dn_i_f%0d", f), obs_i[5], dn_i[f]);
    end

    set_dir(200, 100);
    run_frame(255, 0, 0, -1, 0, 0, -1);
    chk("jump_i", obs_i[5], 200);
    chk("freeze_p", obs_p[7], 4);
    set_dir(0, 100);
    run_frame(0, 0, 0, 50, 5, 5, -1);
    chk("freeze_i_midchg", obs_i[5], 200);
    chk("freeze_p_midchg", obs_p[7], 4);
    set_dir(0, 100);
    run_frame(5, 5, 0, -1, 0, 0, -1);
    chk("step5_i", obs_i[5], 195);
    chk("step5_p", obs_p[7], 9);

    rand_tgts();
    run_frame(20, 20, 1, -1, 0, 0, -1);
    for (int f = 0; f < 4; f++) begin
      rand_tgts();
      run_frame($urandom_range(0, 255), $urandom_range(0, 255), 2,
                $urandom_range(1, DEPTH - 1), $urandom_range(0, 255),
                $urandom_range(0, 255), -1);
    end

    rand_tgts();
    run_frame(40, 40, 2, -1, 0, 0, 120);
    rand_tgts();
    run_frame(0, 0, 0, -1, 0, 0, -1);
    chk("post_rst_i5", obs_i[5], 0);
    chk("post_rst_i248", obs_i[248], 0);
    chk("post_rst_p248", obs_p[248], 0);
    rand_tgts();
    tgt_p[9] = 8'd128;
    run_frame(0, 16, 0, -1, 0, 0, -1);
    chk("tie_positive", obs_p[9], 16);

    for (int f = 0; f < 3; f++) begin
      rand_tgts();
      run_frame($urandom_range(0, 40), $urandom_range(0, 160), 2,
                -1, 0, 0, -1);
    end

    idle(6);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
